// File: rtl/sine_freq_detector.sv
// sine_freq_detector: watches an unsigned sample stream for rising midscale
// crossings (with hysteresis), counts enabled samples between crossings, and
// recovers the generator phase increment as 2^A_WIDTH / period using a
// bit-serial restoring divider.
module sine_freq_detector #(
    parameter int A_WIDTH = 8,
    parameter int D_WIDTH = 8,
    parameter int C_WIDTH = 12,
    parameter int HYST    = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic [D_WIDTH-1:0] din_i,
    output logic [C_WIDTH-1:0] period_o,
    output logic [D_WIDTH-1:0] incr_est_o,
    output logic               valid_o,
    output logic               busy_o,
    output logic               dropped_o
);

    localparam int QW = A_WIDTH + 1;             // quotient width (2^A / 1 needs A+1 bits)
    localparam int BW = $clog2(QW + 1);
    localparam logic [D_WIDTH:0]      MID      = {2'b01, {(D_WIDTH-1){1'b0}}};
    localparam logic [D_WIDTH:0]      LO       = MID - (D_WIDTH+1)'(HYST);
    localparam logic [D_WIDTH:0]      HI       = MID + (D_WIDTH+1)'(HYST);
    localparam logic [C_WIDTH-1:0]    CNT_MAX  = '1;
    localparam logic [BW-1:0]         LAST_BIT = BW'(A_WIDTH);
    localparam logic [QW+D_WIDTH-1:0] SAT_LIM  = {{QW{1'b0}}, {D_WIDTH{1'b1}}};

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t               state_q, state_d;
    logic                 armed_q, armed_d;
    logic                 seen_q, seen_d;
    logic                 ovf_q, ovf_d;
    logic [C_WIDTH-1:0]   cnt_q, cnt_d;
    logic [C_WIDTH-1:0]   meas_q;
    logic [C_WIDTH-1:0]   rem_q;
    logic [QW-1:0]        quot_q;
    logic [BW-1:0]        bit_q;
    logic [C_WIDTH-1:0]   period_q;
    logic [D_WIDTH-1:0]   incr_q;
    logic                 valid_q, dropped_q;

    logic [D_WIDTH:0]     din_ext;
    logic                 crossing, start, drop;
    logic [C_WIDTH:0]     rem_sh, rem_sub;
    logic                 rem_ge;
    logic [QW+D_WIDTH-1:0] q_ext;
    logic [D_WIDTH-1:0]   incr_sat;

    // Crossing qualification: only enabled samples count; a measurement needs a
    // prior crossing, a non-saturated counter and an idle divider.
    always_comb begin
        din_ext  = {1'b0, din_i};
        crossing = en_i && armed_q && (din_ext >= HI);
        start    = crossing && seen_q && !ovf_q && (state_q == IDLE);
        drop     = crossing && seen_q && (ovf_q || (state_q != IDLE));
    end

    // Arming, first-crossing flag and saturating period counter next state.
    always_comb begin
        armed_d = armed_q;
        seen_d  = seen_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        if (en_i) begin
            if (crossing) begin
                armed_d = 1'b0;
                seen_d  = 1'b1;
                cnt_d   = C_WIDTH'(1);
                ovf_d   = 1'b0;
            end else begin
                if (din_ext <= LO) armed_d = 1'b1;
                // ovf only once an increment past the top is attempted, so a
                // period of exactly CNT_MAX is still measurable.
                if (cnt_q == CNT_MAX) ovf_d = 1'b1;
                else                  cnt_d = cnt_q + C_WIDTH'(1);
            end
        end
    end

    // Sample-side state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            armed_q <= 1'b0;
            seen_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            armed_q <= armed_d;
            seen_q  <= seen_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Divider FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Divider FSM next state: A_WIDTH+1 shift/subtract steps, then one publish cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = DIV;
            DIV:     if (bit_q == LAST_BIT) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: busy covers both the shifting and the publish cycle.
    always_comb begin
        busy_o = (state_q != IDLE);
    end

    // Restoring divider step and quotient saturation into D_WIDTH bits.
    always_comb begin
        rem_sh   = {rem_q, quot_q[QW-1]};
        rem_ge   = (rem_sh >= {1'b0, meas_q});
        rem_sub  = rem_sh - {1'b0, meas_q};
        q_ext    = (QW+D_WIDTH)'(quot_q);
        incr_sat = (q_ext > SAT_LIM) ? {D_WIDTH{1'b1}} : q_ext[D_WIDTH-1:0];
    end

    // Divider datapath and registered result/pulse outputs. quot_q starts as
    // the dividend and fills with quotient bits from the bottom as it shifts.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meas_q    <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            bit_q     <= '0;
            period_q  <= '0;
            incr_q    <= '0;
            valid_q   <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            dropped_q <= drop;
            case (state_q)
                IDLE: if (start) begin
                    meas_q <= cnt_q;
                    rem_q  <= '0;
                    quot_q <= {1'b1, {A_WIDTH{1'b0}}};
                    bit_q  <= '0;
                end
                DIV: begin
                    rem_q  <= rem_ge ? rem_sub[C_WIDTH-1:0] : rem_sh[C_WIDTH-1:0];
                    quot_q <= {quot_q[QW-2:0], rem_ge};
                    bit_q  <= bit_q + BW'(1);
                end
                DONE: begin
                    period_q <= meas_q;
                    incr_q   <= incr_sat;
                    valid_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign period_o   = period_q;
    assign incr_est_o = incr_q;
    assign valid_o    = valid_q;
    assign dropped_o  = dropped_q;

endmodule

// File: tb/tb_sine_freq_detector.sv
// Bench for sine_freq_detector: sine/square stimulus against an event-level
// reference (timestamps for division windows, integer divide for the result).
module tb_sine_freq_detector;

    localparam int A = 8, D = 8, C = 12, H = 16;
    localparam int LO = 128 - H, HI = 128 + H, CMAX = 4095;

    logic        clk = 1'b0, rst = 1'b0, en = 1'b0;
    logic [7:0]  din = 8'd0;
    logic [11:0] period_o;
    logic [7:0]  incr_est_o;
    logic        valid_o, busy_o, dropped_o;

    sine_freq_detector #(.A_WIDTH(A), .D_WIDTH(D), .C_WIDTH(C), .HYST(H)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .din_i(din),
        .period_o(period_o), .incr_est_o(incr_est_o), .valid_o(valid_o),
        .busy_o(busy_o), .dropped_o(dropped_o));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // reference state
    bit m_armed, m_seen, m_ovf;
    int m_cnt, cyc = 0, div_start = -1000, pend_cyc = -1, pend_period, pend_incr;
    int exp_last_period = 0, exp_last_incr = 0, exp_valid_n = 0, exp_drop_n = 0;
    // observations
    int cyc_err = 0, obs_valid = 0, obs_drop = 0, last_vcyc = 0, prev_vcyc = 0;
    // generators
    int phase = 0, sq_k = 0;
    bit tog = 1'b0;

    function automatic logic [7:0] sine(input int ph);
        real r;
        r = 128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * real'(ph) / 256.0);
        return 8'(int'(r));
    endfunction

    task automatic model_reset();
        m_armed = 0; m_seen = 0; m_ovf = 0; m_cnt = 0;
        div_start = -1000; pend_cyc = -1;
        exp_last_period = 0; exp_last_incr = 0;
    endtask

    // One sample: drive, advance reference at the edge, tally agreement after it.
    task automatic step(input logic e, input logic [7:0] d);
        bit drop_now, exp_v, exp_b;
        en = e; din = d;
        @(posedge clk);
        cyc++;
        drop_now = 0;
        if (e) begin
            if (m_armed && int'(d) >= HI) begin
                if (!m_seen) m_seen = 1;
                else if (m_ovf || cyc <= div_start + A + 2) drop_now = 1;
                else begin
                    div_start   = cyc;
                    pend_cyc    = cyc + A + 2;
                    pend_period = m_cnt;
                    pend_incr   = ((1 << A) / m_cnt > 255) ? 255 : (1 << A) / m_cnt;
                end
                m_cnt = 1; m_ovf = 0; m_armed = 0;
            end else begin
                if (int'(d) <= LO) m_armed = 1;
                if (m_cnt == CMAX) m_ovf = 1; else m_cnt++;
            end
        end
        exp_v = (cyc == pend_cyc);
        exp_b = (cyc >= div_start) && (cyc <= div_start + A + 1);
        #1;
        if (valid_o !== exp_v || dropped_o !== drop_now || busy_o !== exp_b) cyc_err++;
        if (exp_v) begin
            exp_valid_n++; exp_last_period = pend_period; exp_last_incr = pend_incr;
        end
        if (drop_now) exp_drop_n++;
        if (valid_o === 1'b1) begin
            obs_valid++; prev_vcyc = last_vcyc; last_vcyc = cyc;
            if (int'(period_o) != pend_period || int'(incr_est_o) != pend_incr) cyc_err++;
        end
        if (dropped_o === 1'b1) obs_drop++;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; en = 1'b0;
        repeat (n) begin
            @(posedge clk); cyc++; #1;
            if (valid_o !== 1'b0 || dropped_o !== 1'b0) cyc_err++;
        end
        model_reset();
        rst = 1'b0;
    endtask

    // kind: 0 sine, 1 sine with en toggling, 2 square 3/3, 3 alternating 0/255
    task automatic gen_sample(input int kind, input int incr);
        case (kind)
            0: begin step(1'b1, sine(phase)); phase = (phase + incr) % 256; end
            1: begin
                if (tog) begin step(1'b1, sine(phase)); phase = (phase + incr) % 256; end
                else step(1'b0, 8'($urandom));
                tog = !tog;
            end
            2: begin step(1'b1, ((sq_k / 3) % 2 != 0) ? 8'd255 : 8'd0); sq_k++; end
            default: begin step(1'b1, (sq_k % 2 != 0) ? 8'd255 : 8'd0); sq_k++; end
        endcase
    endtask

    task automatic run_until(input int kind, input int incr, input int k, input int budget,
                             output bit ok);
        int v0, n;
        v0 = obs_valid; n = 0;
        while (obs_valid < v0 + k && n < budget) begin gen_sample(kind, incr); n++; end
        ok = (obs_valid >= v0 + k);
    endtask

    task automatic test_reset();
        do_reset(3);
        checks++; if (period_o !== 12'd0 || incr_est_o !== 8'd0) begin errors++;
            $display("FAIL reset_data period=%0d incr=%0d want 0/0", period_o, incr_est_o); end
        checks++; if (valid_o !== 1'b0 || dropped_o !== 1'b0) begin errors++;
            $display("FAIL reset_pulses valid=%b dropped=%b want 0/0", valid_o, dropped_o); end
        checks++; if (busy_o !== 1'b0) begin errors++;
            $display("FAIL reset_busy busy=%b want 0", busy_o); end
    endtask

    task automatic test_incr1();
        bit ok; int e0;
        e0 = cyc_err; phase = $urandom_range(0, 255);
        run_until(0, 1, 1, 900, ok);
        checks++; if (!ok) begin errors++; $display("FAIL incr1_timeout got no valid want 1"); end
        checks++; if (period_o !== 12'd256 || incr_est_o !== 8'd1) begin errors++;
            $display("FAIL incr1_result period=%0d incr=%0d want 256/1", period_o, incr_est_o); end
        checks++; if (cyc_err != e0 || obs_valid != exp_valid_n) begin errors++;
            $display("FAIL incr1_model cycle_mismatches=%0d valids=%0d want 0/%0d",
                     cyc_err - e0, obs_valid, exp_valid_n); end
    endtask

    task automatic test_incr4();
        bit ok; int e0;
        e0 = cyc_err;
        run_until(0, 4, 3, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL incr4_timeout valids short"); end
        checks++; if (period_o !== 12'd64 || incr_est_o !== 8'd4) begin errors++;
            $display("FAIL incr4_result period=%0d incr=%0d want 64/4", period_o, incr_est_o); end
        checks++; if (last_vcyc - prev_vcyc != 64) begin errors++;
            $display("FAIL incr4_spacing got %0d want 64", last_vcyc - prev_vcyc); end
        checks++; if (cyc_err != e0) begin errors++;
            $display("FAIL incr4_model cycle_mismatches=%0d want 0", cyc_err - e0); end
    endtask

    task automatic test_square6();
        bit ok; int e0;
        e0 = cyc_err; sq_k = 0;
        run_until(2, 0, 2, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL sq6_timeout valids short"); end
        checks++; if (period_o !== 12'd6 || incr_est_o !== 8'd42) begin errors++;
            $display("FAIL sq6_result period=%0d incr=%0d want 6/42", period_o, incr_est_o); end
        checks++; if (cyc_err != e0) begin errors++;
            $display("FAIL sq6_model cycle_mismatches=%0d want 0", cyc_err - e0); end
    endtask

    task automatic test_back_to_back();
        int e0, d0, v0;
        e0 = cyc_err; d0 = obs_drop; v0 = obs_valid; sq_k = 0;
        repeat (60) gen_sample(3, 0);
        checks++; if (period_o !== 12'd2 || incr_est_o !== 8'd128) begin errors++;
            $display("FAIL p2_result period=%0d incr=%0d want 2/128", period_o, incr_est_o); end
        checks++; if (obs_drop - d0 < 10) begin errors++;
            $display("FAIL p2_drops got %0d want >=10", obs_drop - d0); end
        checks++; if (cyc_err != e0 || obs_drop != exp_drop_n || obs_valid != exp_valid_n) begin
            errors++; $display("FAIL p2_model mismatches=%0d drops=%0d/%0d valids=%0d/%0d",
                cyc_err - e0, obs_drop, exp_drop_n, obs_valid, exp_valid_n); end
    endtask

    task automatic test_overflow();
        bit ok; int e0, d0, v0, n;
        e0 = cyc_err;
        repeat (4200) step(1'b1, 8'd128);
        d0 = obs_drop; v0 = obs_valid; n = 0;
        while (obs_drop == d0 && n < 200) begin gen_sample(0, 4); n++; end
        checks++; if (obs_drop == d0) begin errors++; $display("FAIL ovf_drop_timeout no dropped pulse"); end
        checks++; if (obs_valid != v0) begin errors++;
            $display("FAIL ovf_no_valid got %0d valids want 0", obs_valid - v0); end
        run_until(0, 4, 1, 200, ok);
        checks++; if (!ok || period_o !== 12'd64 || incr_est_o !== 8'd4) begin errors++;
            $display("FAIL ovf_recover ok=%b period=%0d incr=%0d want 64/4", ok, period_o, incr_est_o); end
        checks++; if (cyc_err != e0) begin errors++;
            $display("FAIL ovf_model cycle_mismatches=%0d want 0", cyc_err - e0); end
    endtask

    task automatic test_en_reset();
        bit ok; int e0, n, v0;
        e0 = cyc_err; phase = $urandom_range(0, 255);
        run_until(1, 8, 2, 500, ok);
        checks++; if (!ok || period_o !== 12'd32 || incr_est_o !== 8'd8) begin errors++;
            $display("FAIL en50_result ok=%b period=%0d incr=%0d want 32/8", ok, period_o, incr_est_o); end
        n = 0;
        while (busy_o !== 1'b1 && n < 200) begin gen_sample(1, 8); n++; end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL en50_busy_timeout busy never rose"); end
        gen_sample(1, 8); gen_sample(1, 8);
        v0 = obs_valid;
        do_reset(1);
        checks++; if (period_o !== 12'd0 || incr_est_o !== 8'd0 || busy_o !== 1'b0) begin errors++;
            $display("FAIL midiv_reset period=%0d incr=%0d busy=%b want 0/0/0", period_o, incr_est_o, busy_o); end
        repeat (20) gen_sample(1, 8);
        checks++; if (obs_valid != v0) begin errors++;
            $display("FAIL midiv_no_valid got %0d valids want 0", obs_valid - v0); end
        run_until(1, 8, 1, 400, ok);
        checks++; if (!ok || period_o !== 12'd32 || incr_est_o !== 8'd8) begin errors++;
            $display("FAIL reacq ok=%b period=%0d incr=%0d want 32/8", ok, period_o, incr_est_o); end
        checks++; if (cyc_err != e0) begin errors++;
            $display("FAIL en50_model cycle_mismatches=%0d want 0", cyc_err - e0); end
    endtask

    // Random square-ish waves, random enable density, random in-band noise.
    task automatic test_random();
        int e0, hi_n, lo_n, pen, k;
        logic [7:0] v;
        for (int it = 0; it < 6; it++) begin
            e0 = cyc_err;
            hi_n = $urandom_range(1, 20); lo_n = $urandom_range(1, 20); pen = $urandom_range(40, 100);
            if (it == 3) do_reset(2);
            for (int s = 0; s < 300; s++) begin
                k = s % (hi_n + lo_n);
                if (k < lo_n) v = 8'($urandom_range(0, LO));
                else          v = 8'($urandom_range(HI, 255));
                if ($urandom_range(0, 9) == 0) v = 8'($urandom_range(LO + 1, HI - 1));
                step(($urandom_range(1, 100) <= pen) ? 1'b1 : 1'b0, v);
            end
            checks++; if (cyc_err != e0 || int'(period_o) != exp_last_period ||
                          int'(incr_est_o) != exp_last_incr) begin errors++;
                $display("FAIL random%0d mismatches=%0d period=%0d/%0d incr=%0d/%0d", it,
                    cyc_err - e0, period_o, exp_last_period, incr_est_o, exp_last_incr); end
        end
        checks++; if (obs_valid != exp_valid_n || obs_drop != exp_drop_n) begin errors++;
            $display("FAIL totals valids=%0d want %0d drops=%0d want %0d",
                     obs_valid, exp_valid_n, obs_drop, exp_drop_n); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_incr1();
        test_incr4();
        test_square6();
        test_back_to_back();
        test_overflow();
        test_en_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
